// File: rtl/sar_adc_core_if.sv
// sar_adc_core_if: analog input, conversion request and code/strobe outputs of the SAR ADC core.
interface sar_adc_core_if #(
    parameter int NBITS = 8
);
    real              vin;
    logic             start;
    logic             busy;
    logic             valid;
    logic [NBITS-1:0] dout;
    modport master (output vin, start, input busy, valid, dout);
    modport slave  (input vin, start, output busy, valid, dout);
endinterface

// File: rtl/sar_adc_core.sv
// sar_adc_core: behavioural SAR ADC, samples vin on start and resolves an NBITS code MSB-first,
// one bit per clock against an ideal binary DAC, then strobes valid for one cycle.
module sar_adc_core #(
    parameter int  NBITS  = 8,
    parameter real VREF_P = 1.0,
    parameter real VREF_N = 0.0
) (
    input logic           clk,
    input logic           rst_n,
    sar_adc_core_if.slave adc
);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    typedef enum logic {IDLE, CONV} state_t;
    state_t           r_state;
    real              r_vhold;
    logic [NBITS-1:0] r_code;
    logic [IW-1:0]    r_bit_idx;
    real              w_vdac;
    logic [NBITS-1:0] w_next;
    // Trial code for the current bit is already set in r_code; decide it and arm the next one.
    always_comb begin
        w_vdac = VREF_N + real'(r_code) * (VREF_P - VREF_N) / real'(2 ** NBITS);
        w_next = r_code;
        w_next[r_bit_idx] = (r_vhold >= w_vdac);
        if (r_bit_idx != '0) w_next[r_bit_idx - 1'b1] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vhold   <= 0.0;
            r_code    <= '0;
            r_bit_idx <= '0;
            adc.busy  <= 1'b0;
            adc.valid <= 1'b0;
            adc.dout  <= '0;
        end else begin
            adc.valid <= 1'b0;
            if (r_state == IDLE) begin
                if (adc.start) begin
                    r_vhold   <= adc.vin;
                    r_code    <= NBITS'(1) << (NBITS - 1);
                    r_bit_idx <= IW'(NBITS - 1);
                    adc.busy  <= 1'b1;
                    r_state   <= CONV;
                end
            end else begin
                r_code <= w_next;
                if (r_bit_idx == '0) begin
                    adc.dout  <= w_next;
                    adc.valid <= 1'b1;
                    adc.busy  <= 1'b0;
                    r_state   <= IDLE;
                end else begin
                    r_bit_idx <= r_bit_idx - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sar_adc_core.sv
// tb_sar_adc_core: directed and randomized conversions checked against an ideal transfer-function model.
module tb_sar_adc_core;
    localparam int  NB = 8;
    localparam real VP = 1.0;
    localparam real VN = 0.0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    sar_adc_core_if #(.NBITS(NB)) bus ();
    sar_adc_core #(.NBITS(NB), .VREF_P(VP), .VREF_N(VN)) dut (.clk(clk), .rst_n(rst_n), .adc(bus));
    always #5 clk = ~clk;

    function automatic int model(input real v);
        real x;
        x = (v - VN) * real'(2 ** NB) / (VP - VN);
        if (x < 0.0) return 0;
        if (x >= real'(2 ** NB)) return 2 ** NB - 1;
        return int'($floor(x));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic conv(input string tag, input real v, input real v_after, input bit noisy_start);
        int exp;
        exp = model(v);
        @(negedge clk);
        bus.vin = v;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.vin = v_after;
        for (int i = 0; i < NB; i++) begin
            chk({tag, "_busy"}, int'(bus.busy), 1);
            chk({tag, "_early_valid"}, int'(bus.valid), 0);
            if (noisy_start) bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk({tag, "_valid"}, int'(bus.valid), 1);
        chk({tag, "_busy_done"}, int'(bus.busy), 0);
        chk({tag, "_dout"}, int'(bus.dout), exp);
        @(negedge clk);
        chk({tag, "_valid_drop"}, int'(bus.valid), 0);
        chk({tag, "_dout_hold"}, int'(bus.dout), exp);
    endtask

    initial begin
        int pend_done, pend_code, nfree, last_valid, n_valid;
        real v;
        bus.vin = 0.0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_dout", int'(bus.dout), 0);
        rst_n = 1'b1;
        conv("mid", 0.5, 0.5, 1'b0);
        conv("mid_low", 0.4999, 0.4999, 1'b0);
        conv("q1", 0.2519, 0.2519, 1'b0);
        conv("q3", 0.75, 0.75, 1'b0);
        conv("tie_lsb", 1.0 / 256.0, 1.0 / 256.0, 1'b0);
        conv("zero", 0.0, 0.0, 1'b0);
        conv("clamp_hi", 1.2, 1.2, 1'b0);
        conv("clamp_lo", -0.1, -0.1, 1'b0);
        conv("hold", 0.3, 0.9, 1'b0);
        for (int k = 0; k < 16; k++) begin
            v = real'($urandom_range(0, 140000)) / 100000.0 - 0.2;
            conv("rand", v, real'($urandom_range(0, 100000)) / 100000.0, 1'b1);
        end
        // Abort a conversion with a sub-cycle reset pulse a little after edge E+4.
        @(negedge clk);
        bus.vin = 0.6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_valid", int'(bus.valid), 0);
        chk("abort_dout", int'(bus.dout), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_valid", int'(bus.valid), 0);
        end
        conv("post_abort", 0.6, 0.6, 1'b0);
        // Continuous start on a sine source: the model accepts a sample whenever it is free.
        pend_done = -1;
        pend_code = 0;
        nfree = 0;
        last_valid = -1;
        n_valid = 0;
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            bus.vin = 0.5 + 0.49 * $sin(2.0 * 3.14159265358979 * real'(k) / 37.0);
            bus.start = 1'b1;
            @(posedge clk);
            if (k >= nfree) begin
                nfree = k + NB + 1;
                pend_done = k + NB;
                pend_code = model(bus.vin);
            end
            @(negedge clk);
            chk("sine_valid", int'(bus.valid), int'(pend_done == k));
            if (bus.valid) begin
                n_valid++;
                chk("sine_dout", int'(bus.dout), pend_code);
                if (last_valid >= 0) chk("sine_spacing", k - last_valid, NB + 1);
                last_valid = k;
            end
        end
        bus.start = 1'b0;
        chk("sine_count", n_valid, 22);
        repeat (NB + 2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
